ethernet_stats_counters: RTL
============================

# ethernet_stats_counters

Per-port Ethernet RX statistics counter bank, directly downstream of the MAC receive path that emits one `ether_stats_vector` per completed frame. Each asserted bit of the vector increments its own counter. Software reads the counters through a single-cycle-latency read port. It is instantiated once per MAC port and feeds the switch management register block.

## Interface
Parameters:
- `COUNTER_WIDTH`, default 32: width of every counter and of `rd_data`.
- `SATURATE`, default 1: 1 means counters stick at all-ones; 0 means counters wrap to 0.

Ports:
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `stats_valid` input 1: one-cycle strobe qualifying `stats_vector`.
- `stats_vector` input `ethernet_stats_pkg::ether_stats_vector` (`N_OF_ETHER_STATS_TYPE` = 7): per-frame event flags, packed order.
- `clr` input 1: synchronous clear of all counters.
- `rd_req` input 1: read request.
- `rd_addr` input 3: counter index.
- `rd_ack` output 1: read response strobe.
- `rd_data` output `COUNTER_WIDTH`: read response data.
- `ovf` output 7: sticky per-counter overflow/saturation flag.

## Operation
- Counter index equals the packed bit position:
  - 0 = unicast_frame
  - 1 = mcast_frame
  - 2 = bcast_frame
  - 3 = oversized_frame
  - 4 = undersized_frame
  - 5 = bad_crc_frame
  - 6 = valid_frame
- On a cycle with `stats_valid`=1, every counter whose vector bit is 1 increments by exactly 1. Multiple bits may be set together; each affected counter increments independently. When `stats_valid`=0 the vector is ignored.
- Overflow:
  - `SATURATE`=1: an increment at all-ones holds all-ones and sets `ovf[i]`.
  - `SATURATE`=0: an increment at all-ones wraps to 0 and sets `ovf[i]`.
  - `ovf[i]` stays set until `clr` or reset.
- `clr`=1 zeroes all counters and `ovf` on the next edge. It has priority over same-cycle increments and clear-on-read; the increment is lost.
- Read port:
  - `rd_req` is accepted on every cycle with no backpressure, so back-to-back reads are legal.
  - `rd_addr` 0..6 returns that counter.
  - `rd_addr`=7 returns 0, still with `rd_ack`.
  - Read data is the counter value *before* any same-cycle increment or clear.
- No state machine beyond the counters, the `ovf` flags and the registered read stage.

## Timing
- Reset values: all counters 0, `ovf`=0, `rd_ack`=0, `rd_data`=0.
- Increment latency: `stats_valid` in cycle N; the new count is visible to a read issued in cycle N+1.
- Read latency: `rd_req` in cycle N gives `rd_ack`=1 with `rd_data` valid in cycle N+1.
  - `rd_ack` is a one-cycle pulse per request.
  - `rd_data` holds its last value when `rd_ack`=0.
- A read and an increment of the same counter in the same cycle: the read returns the old value, and the counter still increments.
- Reset asserted mid-read: `rd_ack` drops to 0 immediately (asynchronously). The pending response is discarded.

## Configuration
- `ETHER_STATS_CLEAR_ON_READ_EN` defined: an accepted read of index 0..6 also resets that counter and its `ovf` bit on the same edge.
  - If an increment of that counter coincides with the read, the counter becomes 1 rather than 0.
  - `clr` still overrides, giving 0.
- `ETHER_STATS_CLEAR_ON_READ_EN` undefined: reads are non-destructive and counters change only by increment, `clr` or reset.

## Test plan
- After reset, read indices 0..7 back-to-back -> 8 consecutive `rd_ack` pulses, each one cycle after its request, all `rd_data`=0.
- 5 strobes with vector = valid_frame|bcast_frame (0x44), then read 6 and 2 -> both return 5, all other counters 0; `stats_vector`=0x7F with `stats_valid`=0 causes no change.
- `COUNTER_WIDTH`=4, 17 strobes on bad_crc_frame:
  - `SATURATE`=1 -> read 15, `ovf[5]`=1.
  - `SATURATE`=0 -> read 1, `ovf[5]`=1.
- Read of index 0 in the same cycle as a unicast strobe, with counter at 3:
  - Macro undefined -> `rd_data`=3, and the next read returns 4.
  - Macro defined -> `rd_data`=3, and the next read returns 1.
- `clr` in the same cycle as a strobe of 0x41 with counters at 9 -> all counters read 0, `ovf`=0.
- `rst_n` pulsed low in the cycle after `rd_req` -> `rd_ack` stays 0 and all counters read 0 after release.

Source files
------------

// File: rtl/ethernet_stats_counters.sv
// ============================================================================
// ethernet_stats_counters : per-port Ethernet RX statistics counter bank
// Optional: ETHER_STATS_CLEAR_ON_READ_EN makes accepted reads clear the counter
// Revision: 1.0
// ============================================================================
`default_nettype none

package ethernet_stats_pkg;
  localparam int N_OF_ETHER_STATS_TYPE = 7;

  // First member is the MSB, so unicast_frame lands on bit 0.
  typedef struct packed {
    logic valid_frame;
    logic bad_crc_frame;
    logic undersized_frame;
    logic oversized_frame;
    logic bcast_frame;
    logic mcast_frame;
    logic unicast_frame;
  } ether_stats_vector;
endpackage

module ethernet_stats_counters #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SATURATE      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  stats_valid,
  input  ethernet_stats_pkg::ether_stats_vector stats_vector,
  input  logic                                  clr,
  input  logic                                  rd_req,
  input  logic [2:0]                            rd_addr,
  output logic                                  rd_ack,
  output logic [COUNTER_WIDTH-1:0]              rd_data,
  output logic [6:0]                            ovf
);

  localparam int N_CNT = ethernet_stats_pkg::N_OF_ETHER_STATS_TYPE;

  logic [COUNTER_WIDTH-1:0] cnt [N_CNT];
  logic [N_CNT-1:0]         evt;
  logic [N_CNT-1:0]         inc;
  logic [COUNTER_WIDTH-1:0] rd_mux;

  assign evt = stats_vector;
  assign inc = {N_CNT{stats_valid}} & evt;

  // Index 7 has no counter behind it and reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (rd_addr == 3'(i)) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
      ovf     <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) rd_data <= rd_mux;
      for (int i = 0; i < N_CNT; i++) begin
        if (clr) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end
`ifdef ETHER_STATS_CLEAR_ON_READ_EN
        else if (rd_req && (rd_addr == 3'(i))) begin
          cnt[i] <= inc[i] ? COUNTER_WIDTH'(1) : '0;
          ovf[i] <= 1'b0;
        end
`endif
        else if (inc[i]) begin
          if (&cnt[i]) begin
            ovf[i] <= 1'b1;
            if (SATURATE == 0) cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + COUNTER_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
